my_nbit_alu_v2: RTL and testbench
=================================

// Module: my_nbit_alu_v2
// PURPOSE
//   N-bit MIPS-style ALU built from a rippled chain of 1-bit ALU slices: AND, OR, ADD/SUB, SLT.
//   The combinational datapath drives result/flags directly, with same-cycle settle.
//   A clocked status stage captures the last result and flags for downstream pipeline/debug.
//   Sits in the execute stage, driven by the ALU control decoder.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>=2)
// PORTS
//   clk         in   1      clock; status registers update on rising edge
//   rst_n       in   1      reset, asynchronous, active-low
//   in1         in   WIDTH  operand A
//   in2         in   WIDTH  operand B
//   ainvert     in   1      1: use ~A as the A operand
//   bnegate     in   1      1: use ~B as the B operand and carry-in = 1 (subtract)
//   op          in   2      00 AND, 01 OR, 10 ADD/SUB, 11 SLT
//   result      out  WIDTH  combinational result
//   carryOut    out  1      combinational carry out of the MSB slice
//   overflow    out  1      combinational signed overflow (ADD/SUB only)
//   zero        out  1      combinational, 1 when result == 0
//   result_q    out  WIDTH  registered result
//   flags_q     out  3      registered {carryOut, overflow, zero}
// BEHAVIOUR
//   - Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
//   - Operands: a' = ainvert ? ~in1 : in1.  b' = bnegate ? ~in2 : in2.  cin(bit0) = bnegate.
//   - Slices: slice i computes a'&b', a'|b', and sum = a'^b'^c.  Carry ripples LSB to MSB.
//   - op 00: result = a' & b'.  op 01: result = a' | b'.
//   - op 10: result = a' + b' + bnegate, modulo 2^WIDTH.  bnegate=1 gives in1 - in2.
//   - op 11: result = {WIDTH-1 zeros, set}.  Slices 1..WIDTH-1 take less = 0; slice 0 takes less = set.
//     set = sum[MSB] ^ ovf_raw, a signed compare that is correct under overflow.
//   - ovf_raw = (a'[MSB] == b'[MSB]) && (sum[MSB] != a'[MSB]).
//   - overflow = ovf_raw only when op == 10; 0 for AND, OR and SLT.
//   - carryOut = carry out of the MSB slice for every op.  It is meaningful for op 10/11 only.
//   - zero = ~|result for every op, including SLT.
//   - Combinational outputs have zero latency; there is no handshake.
//   - Status stage: on each clk rising edge, result_q <= result and flags_q <= {carryOut, overflow, zero}.
//   - While rst_n = 0: result_q = 0 and flags_q = 3'b000, asynchronously.
//     Release takes effect at the next edge.  Combinational outputs are unaffected by reset.
//   - Boundaries:
//     - 7FFFFFFF + 1 = 80000000 with overflow = 1.
//     - 80000000 - 1 = 7FFFFFFF with overflow = 1.
//     - 0 - 0 gives zero = 1 and carryOut = 1.
//     - ainvert=1, bnegate=1, op 00 gives NOR.
// CONFIGURATION
//   - ALU_STICKY_OVF_EN defined: adds output ovf_sticky (1 bit).
//     It is set on any clk edge where overflow = 1 and stays set until rst_n = 0.  Reset value is 0.
//   - ALU_STICKY_OVF_EN undefined: no ovf_sticky port and no extra register.  All other behaviour is identical.
// TESTING
//   1. AND: in1=FFFFFFFF, in2=A0A0A0A0, op=00 -> result=A0A0A0A0, overflow=0, zero=0.
//      AND: in1=7FFFFFFE, in2=1, op=00 -> result=0, zero=1.
//   2. OR: in1=7FFFFFFE, in2=A0A0A0A0, op=01 -> result=FFFFFFFE, zero=0.
//   3. ADD: in1=7FFFFFFE, in2=A0A0A0A0, op=10 -> result=20A0A09E, overflow=0.
//      ADD: in1=7FFFFFFF, in2=1 -> result=80000000, overflow=1.
//   4. SUB (bnegate=1, op=10): 1-2 -> FFFFFFFF, overflow=0.
//      SUB: 1-1 -> 0, zero=1.
//      SUB: 80000000-1 -> 7FFFFFFF, overflow=1.
//   5. SLT (bnegate=1, op=11): 00FFFFFF vs 0F000000 -> result=1, zero=0.
//      SLT: 0FFFFFFF vs 1 -> result=0, zero=1.
//      SLT: 80000000 vs 1 -> result=1, overflow=0.
//   6. Registers:
//      - Assert rst_n=0 mid-run -> result_q=0 and flags_q=0 immediately.
//      - After release, one clk edge with 7FFFFFFF+1 -> result_q=80000000, flags_q=010.
//      - With ALU_STICKY_OVF_EN: ovf_sticky=1 and stays 1 after later non-overflow ops.

Source files
------------

// File: rtl/my_nbit_alu_v2.sv
// N-bit MIPS-style ALU (AND, OR, ADD/SUB, SLT) built from a rippled chain of 1-bit slices,
// with a registered status stage. Optional ALU_STICKY_OVF_EN adds a sticky overflow output.
module my_nbit_alu_v2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ainvert,
    input  logic             bnegate,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero,
`ifdef ALU_STICKY_OVF_EN
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] result_q,
    output logic [2:0]       flags_q
);

    localparam int unsigned Msb = WIDTH - 1;

    typedef enum logic [1:0] {
        OpAnd = 2'b00,
        OpOr  = 2'b01,
        OpAdd = 2'b10,
        OpSlt = 2'b11
    } alu_op_e;

    logic [WIDTH-1:0] a_p;
    logic [WIDTH-1:0] b_p;
    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] sum_v;
    logic [WIDTH-1:0] less_v;
    logic             carry_msb;
    logic             ovf_raw;
    logic             set;
    alu_op_e          op_e;

    assign op_e = alu_op_e'(op);

    assign a_p = ainvert ? ~in1 : in1;
    assign b_p = bnegate ? ~in2 : in2;

    // Ripple chain: each iteration is one 1-bit slice, carry flows LSB to MSB.
    always_comb begin
        logic c;
        c     = bnegate;
        and_v = '0;
        or_v  = '0;
        sum_v = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            and_v[i] = a_p[i] & b_p[i];
            or_v[i]  = a_p[i] | b_p[i];
            sum_v[i] = a_p[i] ^ b_p[i] ^ c;
            c        = (a_p[i] & b_p[i]) | (c & (a_p[i] ^ b_p[i]));
        end
        carry_msb = c;
    end

    assign ovf_raw = (a_p[Msb] == b_p[Msb]) && (sum_v[Msb] != a_p[Msb]);
    // Sign of the true difference, corrected when the subtraction overflowed.
    assign set     = sum_v[Msb] ^ ovf_raw;

    always_comb begin
        less_v    = '0;
        less_v[0] = set;
    end

    always_comb begin
        result = '0;
        unique case (op_e)
            OpAnd:   result = and_v;
            OpOr:    result = or_v;
            OpAdd:   result = sum_v;
            OpSlt:   result = less_v;
            default: result = '0;
        endcase
    end

    assign carryOut = carry_msb;
    assign overflow = (op_e == OpAdd) ? ovf_raw : 1'b0;
    assign zero     = ~|result;

    // Status stage
    logic [WIDTH-1:0] result_d;
    logic [2:0]       flags_d;

    always_comb begin
        result_d = result;
        flags_d  = {carryOut, overflow, zero};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= 3'b000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic ovf_sticky_q;
    logic ovf_sticky_d;

    always_comb begin
        ovf_sticky_d = ovf_sticky_q | overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_my_nbit_alu_v2.sv
// Directed self-checking bench for my_nbit_alu_v2 (WIDTH=32), including the status stage
// and, when ALU_STICKY_OVF_EN is defined, the sticky overflow output.
module tb_my_nbit_alu_v2;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        ainvert;
    logic        bnegate;
    logic [1:0]  op;
    logic [31:0] result;
    logic        carryOut;
    logic        overflow;
    logic        zero;
    logic [31:0] result_q;
    logic [2:0]  flags_q;
`ifdef ALU_STICKY_OVF_EN
    logic        ovf_sticky;
`endif

    int checks;
    int failures;

    my_nbit_alu_v2 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in1      (in1),
        .in2      (in2),
        .ainvert  (ainvert),
        .bnegate  (bnegate),
        .op       (op),
        .result   (result),
        .carryOut (carryOut),
        .overflow (overflow),
        .zero     (zero),
`ifdef ALU_STICKY_OVF_EN
        .ovf_sticky (ovf_sticky),
`endif
        .result_q (result_q),
        .flags_q  (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic ai,
                         input logic bn, input logic [1:0] o);
        in1     = a;
        in2     = b;
        ainvert = ai;
        bnegate = bn;
        op      = o;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in1      = 32'h0;
        in2      = 32'h0;
        ainvert  = 1'b0;
        bnegate  = 1'b0;
        op       = 2'b00;
        #2;
        check_eq("reset_result_q", result_q, 32'h0);
        check_eq("reset_flags_q", {29'd0, flags_q}, 32'h0);
`ifdef ALU_STICKY_OVF_EN
        check_eq("reset_sticky", {31'd0, ovf_sticky}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // AND
        apply(32'hFFFF_FFFF, 32'hA0A0_A0A0, 1'b0, 1'b0, 2'b00);
        check_eq("and_res", result, 32'hA0A0_A0A0);
        check_eq("and_ovf", {31'd0, overflow}, 32'd0);
        check_eq("and_zero", {31'd0, zero}, 32'd0);
        apply(32'h7FFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 2'b00);
        check_eq("and0_res", result, 32'h0);
        check_eq("and0_zero", {31'd0, zero}, 32'd1);

        // OR
        apply(32'h7FFF_FFFE, 32'hA0A0_A0A0, 1'b0, 1'b0, 2'b01);
        check_eq("or_res", result, 32'hFFFF_FFFE);
        check_eq("or_zero", {31'd0, zero}, 32'd0);

        // ADD
        apply(32'h7FFF_FFFE, 32'hA0A0_A0A0, 1'b0, 1'b0, 2'b10);
        check_eq("add_res", result, 32'h20A0_A09E);
        check_eq("add_ovf", {31'd0, overflow}, 32'd0);
        check_eq("add_cout", {31'd0, carryOut}, 32'd1);
        apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2'b10);
        check_eq("addovf_res", result, 32'h8000_0000);
        check_eq("addovf_ovf", {31'd0, overflow}, 32'd1);
        check_eq("addovf_cout", {31'd0, carryOut}, 32'd0);

        // SUB
        apply(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 2'b10);
        check_eq("sub12_res", result, 32'hFFFF_FFFF);
        check_eq("sub12_ovf", {31'd0, overflow}, 32'd0);
        check_eq("sub12_cout", {31'd0, carryOut}, 32'd0);
        apply(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 2'b10);
        check_eq("sub11_res", result, 32'h0);
        check_eq("sub11_zero", {31'd0, zero}, 32'd1);
        apply(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 2'b10);
        check_eq("subovf_res", result, 32'h7FFF_FFFF);
        check_eq("subovf_ovf", {31'd0, overflow}, 32'd1);
        check_eq("subovf_cout", {31'd0, carryOut}, 32'd1);
        apply(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 2'b10);
        check_eq("sub00_zero", {31'd0, zero}, 32'd1);
        check_eq("sub00_cout", {31'd0, carryOut}, 32'd1);

        // SLT
        apply(32'h00FF_FFFF, 32'h0F00_0000, 1'b0, 1'b1, 2'b11);
        check_eq("slt_lt_res", result, 32'h1);
        check_eq("slt_lt_zero", {31'd0, zero}, 32'd0);
        apply(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 2'b11);
        check_eq("slt_ge_res", result, 32'h0);
        check_eq("slt_ge_zero", {31'd0, zero}, 32'd1);
        apply(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 2'b11);
        check_eq("slt_ovf_res", result, 32'h1);
        check_eq("slt_ovf_ovf", {31'd0, overflow}, 32'd0);

        // NOR
        apply(32'hF0F0_F0F0, 32'h0F0F_0000, 1'b1, 1'b1, 2'b00);
        check_eq("nor_res", result, 32'h0000_0F0F);

        // Status stage: capture an overflowing add
        @(negedge clk);
        apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2'b10);
        @(posedge clk);
        #1;
        check_eq("reg_res", result_q, 32'h8000_0000);
        check_eq("reg_flags", {29'd0, flags_q}, 32'h2);
`ifdef ALU_STICKY_OVF_EN
        check_eq("sticky_set", {31'd0, ovf_sticky}, 32'd1);
`endif
        @(negedge clk);
        apply(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 2'b10);
        @(posedge clk);
        #1;
        check_eq("reg2_res", result_q, 32'h0);
        check_eq("reg2_flags", {29'd0, flags_q}, 32'h5);
`ifdef ALU_STICKY_OVF_EN
        check_eq("sticky_hold", {31'd0, ovf_sticky}, 32'd1);
`endif

        // Asynchronous reset mid-cycle, then release and capture again
        @(negedge clk);
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 2'b01);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_res", result_q, 32'h0);
        check_eq("arst_flags", {29'd0, flags_q}, 32'h0);
`ifdef ALU_STICKY_OVF_EN
        check_eq("arst_sticky", {31'd0, ovf_sticky}, 32'd0);
`endif
        check_eq("arst_comb_res", result, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2'b10);
        @(posedge clk);
        #1;
        check_eq("rel_res", result_q, 32'h8000_0000);
        check_eq("rel_flags", {29'd0, flags_q}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
